// File: rtl/keycode_capture.sv
// Keycode capture peripheral: synchronizes an asynchronous keycode, queues each
// change in a small FIFO and exposes it, with status and interrupt, on Avalon-MM.
module keycode_capture #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int CAPTURE_ZERO = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             irq_en;

    logic rd_acc;
    logic wr_acc;
    logic empty;
    logic full;
    logic push;
    logic pop;
    logic do_push;
    logic ovf_set;
    logic ovf_clr;
    logic unused_wdata;

    assign unused_wdata = ^{writedata[31:9], writedata[7:1]};

    always_comb begin
        rd_acc  = chipselect & ~read_n;
        wr_acc  = chipselect & ~write_n;
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        push    = (sync2 != prev) && ((CAPTURE_ZERO != 0) || (sync2 != '0));
        pop     = rd_acc && (address == 2'd1) && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        do_push = push && (!full || pop);
        ovf_set = push && full && !pop;
        ovf_clr = wr_acc && (address == 2'd2) && writedata[8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;

            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);

            unique case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;

            if (wr_acc && (address == 2'd3)) irq_en <= writedata[0];
        end
    end

    // Storage is left unreset; entries are unreachable while count is zero.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= sync2;
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[WIDTH-1:0] = sync2;
            2'd1: begin
                if (!empty) begin
                    readdata[16]          = 1'b1;
                    readdata[WIDTH-1:0]   = mem[rd_ptr];
                end
            end
            2'd2: begin
                readdata[8]   = overflow;
                readdata[4:0] = 5'(count);
            end
            default: readdata[0] = irq_en;
        endcase
    end

    assign irq = irq_en & (!empty | overflow);

endmodule

// File: tb/tb_keycode_capture.sv
// Bench for keycode_capture: two instances (zero capture off/on) share one bus and
// are compared every cycle against a queue-based reference model.
module tb_keycode_capture;

    localparam int W = 8;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          read_n = 1'b1;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [W-1:0]  in_port = '0;
    logic [31:0]   rd_a;
    logic [31:0]   rd_z;
    logic          irq_a;
    logic          irq_z;

    keycode_capture #(.WIDTH(W), .DEPTH(D), .CAPTURE_ZERO(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .in_port(in_port), .readdata(rd_a), .irq(irq_a)
    );

    keycode_capture #(.WIDTH(W), .DEPTH(D), .CAPTURE_ZERO(1)) dut_z (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .in_port(in_port), .readdata(rd_z), .irq(irq_z)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: in_port as seen at the last three edges, one queue per instance.
    logic [W-1:0] h1, h2, h3;
    logic [W-1:0] mq [2][$];
    bit           movf [2];
    bit           men;

    task automatic model_reset();
        h1 = '0; h2 = '0; h3 = '0;
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            movf[i] = 1'b0;
        end
        men = 1'b0;
    endtask

    function automatic logic [31:0] exp_rd(int i, logic [1:0] a);
        case (a)
            2'd0:    return 32'(h2);
            2'd1:    return (mq[i].size() != 0) ? (32'h0001_0000 | 32'(mq[i][0])) : 32'h0;
            2'd2:    return (movf[i] ? 32'h100 : 32'h0) | 32'(mq[i].size());
            default: return 32'(men);
        endcase
    endfunction

    function automatic logic exp_irq(int i);
        return men && ((mq[i].size() != 0) || movf[i]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Look at every register of both instances without a bus strobe, then irq.
    task automatic peek_all(input string tag);
        logic [1:0] saved;
        saved = address;
        for (int unsigned a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            check($sformatf("%s_a_r%0d", tag, a), rd_a, exp_rd(0, 2'(a)));
            check($sformatf("%s_z_r%0d", tag, a), rd_z, exp_rd(1, 2'(a)));
        end
        check({tag, "_a_irq"}, {31'b0, irq_a}, {31'b0, exp_irq(0)});
        check({tag, "_z_irq"}, {31'b0, irq_z}, {31'b0, exp_irq(1)});
        address = saved;
        #1;
    endtask

    // One rising edge; the model applies the same edge with the inputs held now.
    task automatic tick();
        bit rd, wr, pop, push, full;
        rd = chipselect && !read_n;
        wr = chipselect && !write_n;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            pop  = rd && (address == 2'd1) && (mq[i].size() != 0);
            push = (h2 != h3) && ((i == 1) || (h2 != '0));
            full = (mq[i].size() == D);
            if (pop) void'(mq[i].pop_front());
            if (push && (!full || pop)) mq[i].push_back(h2);
            if (push && full && !pop) movf[i] = 1'b1;
            else if (wr && address == 2'd2 && writedata[8]) movf[i] = 1'b0;
        end
        if (wr && address == 2'd3) men = writedata[0];
        h3 = h2; h2 = h1; h1 = in_port;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic look(input logic [1:0] a);
        address = a;
        #1;
    endtask

    task automatic do_read(input string tag, input logic [31:0] exp);
        look(2'd1);
        check({tag, "_a"}, rd_a, exp);
        check({tag, "_model"}, rd_a, exp_rd(0, 2'd1));
        chipselect = 1'b1; read_n = 1'b0;
        tick();
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * D + 2; k++) begin
            address = 2'd1; chipselect = 1'b1; read_n = 1'b0;
            tick();
        end
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    initial begin
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        peek_all("reset");
        look(2'd1);
        check("reset_valid", rd_a, 32'h0);
        reset_n = 1'b1;
        ticks(2);

        // Single change reaches the FIFO two edges after first sampling
        in_port = 8'h1A;
        tick();
        look(2'd2);
        check("lat_k", rd_a, 32'h0);
        tick();
        check("lat_k1", rd_a, 32'h0);
        tick();
        look(2'd2);
        check("lat_k2", rd_a, 32'h1);
        peek_all("lat");
        do_read("single_rd", 32'h0001_001A);
        do_read("single_empty", 32'h0000_0000);

        // Five keycodes without reads: last one dropped, overflow set
        for (int unsigned v = 4; v <= 8; v++) begin
            in_port = 8'(v);
            ticks(2);
        end
        ticks(3);
        look(2'd2);
        check("ovf_status", rd_a, 32'h104);
        peek_all("ovf");
        for (int unsigned v = 4; v <= 7; v++) do_read($sformatf("ovf_rd%0d", v), 32'h0001_0000 | 32'(v));
        do_read("ovf_empty", 32'h0);
        do_write(2'd2, 32'h100);
        look(2'd2);
        check("ovf_clear", rd_a, 32'h0);

        // Full FIFO with push and pop on the same edge
        for (int unsigned v = 8'h11; v <= 8'h14; v++) begin
            in_port = 8'(v);
            ticks(2);
        end
        in_port = 8'h15;
        ticks(2);
        look(2'd2);
        check("full_before", rd_a, 32'h4);
        do_read("full_pp", 32'h0001_0011);
        look(2'd2);
        check("full_after", rd_a, 32'h4);
        peek_all("full");
        for (int unsigned v = 8'h12; v <= 8'h15; v++) do_read($sformatf("full_rd%0h", v), 32'h0001_0000 | 32'(v));

        // Change to zero: captured only with zero capture enabled
        in_port = 8'h1A;
        ticks(4);
        drain();
        in_port = 8'h00;
        ticks(4);
        look(2'd2);
        check("zero_a_cnt", rd_a, 32'h0);
        check("zero_z_cnt", rd_z, 32'h1);
        look(2'd1);
        check("zero_z_head", rd_z, 32'h0001_0000);
        peek_all("zero");
        drain();

        // Interrupt behaviour
        do_write(2'd3, 32'h1);
        in_port = 8'h21;
        ticks(3);
        check("irq_push", {31'b0, irq_a}, 32'h1);
        do_read("irq_rd", 32'h0001_0021);
        check("irq_empty", {31'b0, irq_a}, 32'h0);
        for (int unsigned v = 8'h31; v <= 8'h35; v++) begin
            in_port = 8'(v);
            tick();
        end
        ticks(3);
        drain();
        look(2'd2);
        check("irq_ovf_stat", rd_a, 32'h100);
        check("irq_ovf", {31'b0, irq_a}, 32'h1);
        do_write(2'd2, 32'h100);
        check("irq_cleared", {31'b0, irq_a}, 32'h0);
        peek_all("irq");

        // Asynchronous reset mid-cycle with an access in flight
        for (int unsigned v = 8'h41; v <= 8'h45; v++) begin
            in_port = 8'(v);
            tick();
        end
        ticks(3);
        do_read("rst_pre_rd", 32'h0001_0041);
        look(2'd2);
        check("rst_pre_stat", rd_a, 32'h103);
        check("rst_pre_irq", {31'b0, irq_a}, 32'h1);
        address = 2'd1; chipselect = 1'b1; read_n = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_irq", {31'b0, irq_a}, 32'h0);
        check("rst_irq_z", {31'b0, irq_z}, 32'h0);
        address = 2'd2;
        #1;
        check("rst_stat", rd_a, 32'h0);
        chipselect = 1'b0; read_n = 1'b1;
        peek_all("rst");

        // Non-zero input held through reset release is captured
        in_port = 8'h2B;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        ticks(3);
        look(2'd1);
        check("rel_head", rd_a, 32'h0001_002B);
        peek_all("rel");
        drain();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) in_port = 8'($urandom_range(0, 5));
            chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
            address = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 4) begin
                chipselect = 1'b1;
                read_n = 1'b0;
                if ($urandom_range(0, 1) == 0) address = 2'd1;
            end
            if ($urandom_range(0, 9) == 0) begin
                chipselect = 1'b1;
                write_n = 1'b0;
                writedata = $urandom();
            end
            peek_all($sformatf("rnd%0d", n));
            tick();
        end
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        peek_all("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keycode_capture.md
KEYCODE_CAPTURE -- requirements
Module: keycode_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of captured keycode, range 1..16.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries, power of two, range 2..16.
REQ-003 SHALL have parameter CAPTURE_ZERO, default 0: 1 = also capture changes to all-zero (key release).
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port address  input  2  Avalon-MM register select.
REQ-007 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-008 SHALL have port read_n  input  1  Avalon-MM read strobe, active-low.
REQ-009 SHALL have port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-010 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-011 SHALL have port in_port  input  WIDTH  asynchronous keycode from the USB/keyboard side.
REQ-012 SHALL have port readdata  output  32  Avalon-MM read data, zero wait states, zero read latency.
REQ-013 SHALL have port irq  output  1  interrupt request, active-high, level.

Function
REQ-014 SHALL synchronize in_port through two flops (sync1, sync2), then register sync2 into prev.
REQ-015 SHALL assert push when sync2 != prev and (CAPTURE_ZERO = 1 or sync2 != 0).
REQ-016 SHALL write sync2 into the FIFO tail at the clock edge where push is high; an in_port change settled before edge k is in the FIFO (count incremented) after edge k+2.
REQ-017 SHALL define a read access as chipselect & ~read_n; a write access as chipselect & ~write_n.
REQ-018 SHALL drive readdata combinationally, upper unused bits zero: addr 0 = {0, sync2}; addr 1 = {0, valid(bit 16), FIFO head (bits WIDTH-1:0)}; addr 2 = {0, overflow(bit 8), count(bits 4:0)}; addr 3 = {0, irq_en(bit 0)}.
REQ-019 SHALL set valid = 1 in an addr-1 read iff FIFO non-empty; head bits SHALL be 0 when empty.
REQ-020 SHALL pop the FIFO head at the clock edge ending each addr-1 read access when non-empty; a read on an empty FIFO SHALL change no state.
REQ-021 SHALL treat each cycle with a read access as one pop (the bus master asserts read for one cycle per access).
REQ-022 SHALL, on push with FIFO full and no pop in the same cycle, drop the new keycode, keep contents, and set sticky overflow.
REQ-023 SHALL, on simultaneous push and pop with FIFO full, perform both; count unchanged; overflow not set.
REQ-024 SHALL, on simultaneous push and pop with FIFO empty, return valid = 0 for the read and store the pushed value; count becomes 1.
REQ-025 SHALL keep count in 0..DEPTH with wrapping read/write pointers modulo DEPTH.
REQ-026 SHALL clear overflow on an addr-2 write with writedata[8] = 1; a push-overflow in the same cycle SHALL win (overflow stays 1).
REQ-027 SHALL load irq_en from writedata[0] on an addr-3 write; writes to addr 0 and 1 SHALL be ignored.
REQ-028 SHALL drive irq = irq_en & (count != 0 | overflow), combinationally from registered state.

Reset
REQ-029 SHALL, on reset_n low, asynchronously clear sync1, sync2, prev, pointers, count, overflow, irq_en; readdata then reads 0 on addr 0/2/3 and valid = 0 on addr 1; irq = 0.
REQ-030 SHALL not clear FIFO storage array on reset; contents are unreachable while count = 0.
REQ-031 SHALL, after reset release with in_port held non-zero, capture that value as a normal change from 0.
REQ-032 SHALL abort any access in progress when reset asserts mid-operation; no partial pop or push survives.

Verification
REQ-033 SHALL cover: in_port 0x00->0x1A before edge k -> addr 2 reads count 1 after edge k+2; addr 1 read returns 0x0001_001A, next read 0x0000_0000.
REQ-034 SHALL cover: five distinct keycodes 0x04,0x05,0x06,0x07,0x08 with no reads (DEPTH 4) -> count 4, overflow 1, reads yield 0x04..0x07 then valid 0.
REQ-035 SHALL cover: full FIFO, push and pop in same cycle -> count stays 4, overflow stays 0, new entry last in order.
REQ-036 SHALL cover: in_port 0x1A->0x00 with CAPTURE_ZERO 0 -> no push; with CAPTURE_ZERO 1 -> entry 0x00, valid 1.
REQ-037 SHALL cover: irq_en=1, one push -> irq high; pop to empty -> irq low next cycle; overflow set -> irq high until addr-2 write 0x100.
REQ-038 SHALL cover: reset_n pulsed low with count 3, overflow 1, irq_en 1 -> count 0, overflow 0, irq 0 immediately (asynchronously).
